// File: rtl/apb_cmd_master.sv
// Single-outstanding APB master: valid/ready request in, one APB transfer out, valid/ready response back.
// Optional macro APBM_WSTRB_EN: writes forward the request byte strobes instead of all ones.
module apb_cmd_master #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [AW-1:0]   i_req_addr,
  input  logic            i_req_write,
  input  logic [DW-1:0]   i_req_wdata,
  input  logic [DW/8-1:0] i_req_wstrb,
  input  logic [2:0]      i_req_prot,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [DW-1:0]   o_rsp_rdata,
  output logic            o_rsp_err,
  output logic            o_psel,
  output logic            o_penable,
  output logic            o_pwrite,
  output logic [AW-1:0]   o_paddr,
  output logic [DW-1:0]   o_pwdata,
  output logic [DW/8-1:0] o_pwstrb,
  output logic [2:0]      o_pprot,
  input  logic            i_pready,
  input  logic            i_pslverr,
  input  logic [DW-1:0]   i_prdata
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [DW/8-1:0] pwstrb_q, pwstrb_d;
  logic [2:0]      pprot_q, pprot_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic            req_fire;
  logic            xfer_done;
  logic [DW/8-1:0] wr_strb;

  assign req_fire  = (state_q == IDLE) && i_req_valid;
  // Slave outputs only count in a real access phase.
  assign xfer_done = psel_q && penable_q && i_pready;

`ifdef APBM_WSTRB_EN
  assign wr_strb = i_req_wstrb;
`else
  assign wr_strb = '1;
  logic unused_wstrb;
  assign unused_wstrb = ^i_req_wstrb;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwstrb_q    <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwstrb_q    <= pwstrb_d;
      pprot_q     <= pprot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_req_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (i_pready) state_d = RESP;
      RESP:    if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwstrb_d    = pwstrb_q;
    pprot_d     = pprot_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (req_fire) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = i_req_write;
      paddr_d   = i_req_addr;
      pwdata_d  = i_req_wdata;
      pwstrb_d  = i_req_write ? wr_strb : '0;
      pprot_d   = i_req_prot;
    end
    if (state_q == SETUP) begin
      penable_d = 1'b1;
    end
    if ((state_q == ACCESS) && xfer_done) begin
      psel_d      = 1'b0;
      penable_d   = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = pwrite_q ? '0 : i_prdata;
      rsp_err_d   = i_pslverr;
    end
    if ((state_q == RESP) && i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_psel      = psel_q;
  assign o_penable   = penable_q;
  assign o_pwrite    = pwrite_q;
  assign o_paddr     = paddr_q;
  assign o_pwdata    = pwdata_q;
  assign o_pwstrb    = pwstrb_q;
  assign o_pprot     = pprot_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: drives request/response streams and a scripted APB slave.
// Strobe expectations follow APBM_WSTRB_EN as compiled.
module tb_apb_cmd_master;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_req_addr = '0;
  logic        i_req_write = 1'b0;
  logic [31:0] i_req_wdata = '0;
  logic [3:0]  i_req_wstrb = '0;
  logic [2:0]  i_req_prot = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_psel;
  logic        o_penable;
  logic        o_pwrite;
  logic [31:0] o_paddr;
  logic [31:0] o_pwdata;
  logic [3:0]  o_pwstrb;
  logic [2:0]  o_pprot;
  logic        i_pready = 1'b0;
  logic        i_pslverr = 1'b0;
  logic [31:0] i_prdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  apb_cmd_master #(.AW(32), .DW(32)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_addr  (i_req_addr),
    .i_req_write (i_req_write),
    .i_req_wdata (i_req_wdata),
    .i_req_wstrb (i_req_wstrb),
    .i_req_prot  (i_req_prot),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_psel      (o_psel),
    .o_penable   (o_penable),
    .o_pwrite    (o_pwrite),
    .o_paddr     (o_paddr),
    .o_pwdata    (o_pwdata),
    .o_pwstrb    (o_pwstrb),
    .o_pprot     (o_pprot),
    .i_pready    (i_pready),
    .i_pslverr   (i_pslverr),
    .i_prdata    (i_prdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic xfer(input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input logic [3:0] wstrb,
                      input logic [2:0] prot, input int waits,
                      input logic [31:0] rdata, input logic slverr,
                      input logic junk_err, input int hold);
    logic [3:0]  es;
    logic [31:0] er;
    if (wr) begin
`ifdef APBM_WSTRB_EN
      es = wstrb;
`else
      es = 4'hF;
`endif
    end else begin
      es = 4'h0;
    end
    er = wr ? 32'h0 : rdata;
    check("req_rdy_idle", o_req_ready, 1);
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    i_req_write = wr;
    i_req_wdata = wdata;
    i_req_wstrb = wstrb;
    i_req_prot  = prot;
    tick();
    i_req_valid = 1'b0;
    i_req_addr  = ~addr;
    i_req_wdata = ~wdata;
    i_req_wstrb = ~wstrb;
    check("setup_psel", o_psel, 1);
    check("setup_pen", o_penable, 0);
    check("setup_rdy", o_req_ready, 0);
    check("setup_addr", o_paddr, addr);
    check("setup_pwrite", o_pwrite, wr);
    check("setup_wdata", o_pwdata, wdata);
    check("setup_strb", o_pwstrb, es);
    check("setup_prot", o_pprot, prot);
    i_pready  = 1'b1;
    i_pslverr = 1'b1;
    tick();
    for (int k = 0; k <= waits; k++) begin
      check("acc_psel", o_psel, 1);
      check("acc_pen", o_penable, 1);
      check("acc_addr", o_paddr, addr);
      check("acc_wdata", o_pwdata, wdata);
      check("acc_strb", o_pwstrb, es);
      check("acc_rspv", o_rsp_valid, 0);
      i_pready  = (k == waits);
      i_pslverr = (k == waits) ? slverr : junk_err;
      i_prdata  = (k == waits) ? rdata : 32'h5A5A_5A5A;
      tick();
    end
    i_pready  = 1'b0;
    i_pslverr = 1'b1;
    i_prdata  = 32'hFFFF_0000;
    check("rsp_valid", o_rsp_valid, 1);
    check("rsp_rdata", o_rsp_rdata, er);
    check("rsp_err", o_rsp_err, slverr);
    check("rsp_psel", o_psel, 0);
    check("rsp_pen", o_penable, 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", o_rsp_valid, 1);
      check("hold_rdata", o_rsp_rdata, er);
      check("hold_err", o_rsp_err, slverr);
      check("hold_rdy", o_req_ready, 0);
      check("hold_psel", o_psel, 0);
    end
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    i_pslverr   = 1'b0;
    check("done_valid", o_rsp_valid, 0);
    check("done_rdy", o_req_ready, 1);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_rdy", o_req_ready, 1);
    check("rst_psel", o_psel, 0);
    check("rst_pen", o_penable, 0);
    check("rst_rspv", o_rsp_valid, 0);
    check("rst_addr", o_paddr, 0);
    check("rst_strb", o_pwstrb, 0);
    check("rst_rdata", o_rsp_rdata, 0);
    i_reset = 1'b0;
    tick();

    // zero-wait read
    xfer(32'h10, 1'b0, 32'h0, 4'h0, 3'b010, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 0);
    // write, 3 wait states
    xfer(32'h20, 1'b1, 32'h1234_5678, 4'b0101, 3'b001, 3, 32'hDEAD_BEEF,
         1'b0, 1'b0, 0);
    // read with junk PSLVERR during waits
    xfer(32'h30, 1'b0, 32'h0, 4'hF, 3'b000, 2, 32'h0BAD_F00D, 1'b0, 1'b1, 0);
    // slave error on completion
    xfer(32'h40, 1'b1, 32'hA5A5_0000, 4'b1100, 3'b111, 0, 32'h1, 1'b1,
         1'b0, 0);
    // response backpressure
    xfer(32'h50, 1'b0, 32'h0, 4'h0, 3'b100, 1, 32'h7777_8888, 1'b1, 1'b0, 5);

    // reset while in ACCESS
    i_req_valid = 1'b1;
    i_req_addr  = 32'h60;
    i_req_write = 1'b0;
    tick();
    i_req_valid = 1'b0;
    tick();
    check("mid_pen", o_penable, 1);
    i_reset = 1'b1;
    #1;
    check("arst_psel", o_psel, 0);
    check("arst_pen", o_penable, 0);
    check("arst_rspv", o_rsp_valid, 0);
    i_pready = 1'b1;
    tick();
    i_reset = 1'b0;
    tick();
    i_pready = 1'b0;
    check("post_rdy", o_req_ready, 1);
    check("post_rspv", o_rsp_valid, 0);
    check("post_psel", o_psel, 0);
    tick();
    check("post_rspv2", o_rsp_valid, 0);

    // recovery after reset
    xfer(32'h70, 1'b1, 32'hFEED_FACE, 4'b0011, 3'b011, 0, 32'h0, 1'b0,
         1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
